// File: rtl/pcihellocore_hex_pkg.sv
// Shared types and constants for the four-digit multiplexed hex display scanner.
package pcihellocore_hex_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [31:0] HEX_RESET_PATTERN = 32'h40404040;
  localparam logic [7:0]  SEG_BLANK         = 8'hFF;
  localparam logic [3:0]  DIG_NONE          = 4'hF;

  // Bits needed to hold 0..v-1, never less than one bit.
  function automatic int cnt_width(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pcihellocore_hexscan.sv
// Time-multiplexed scanner for a four-digit seven-segment display with
// per-digit dead time, frame-synchronous pattern snapshot and optional blink.
module pcihellocore_hexscan
  import pcihellocore_hex_pkg::*;
#(
  parameter int DIV          = 50000,
  parameter int DEAD         = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seg_in,
  input  logic        blink_en,
  output logic [7:0]  seg_out,
  output logic [3:0]  dig_sel,
  output logic        frame_tick
);

  localparam int PW = cnt_width((DIV > DEAD) ? DIV : DEAD);
  localparam int BW = cnt_width(BLINK_FRAMES);

  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] DEAD_LAST  = PW'(DEAD - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  state_t          state;
  logic [1:0]      dig_idx;
  logic [PW-1:0]   phase_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_off;
  logic [31:0]     snap;
  logic            frame_end;

  // Last SHOW cycle of digit 3: the only point where a new frame's data is taken.
  assign frame_end = (state == SHOW) && (dig_idx == 2'd3) && (phase_cnt == DIV_LAST);

  // NOTE: every register here uses <= so all updates see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      dig_idx    <= 2'd0;
      phase_cnt  <= '0;
      blink_cnt  <= '0;
      blink_off  <= 1'b0;
      snap       <= HEX_RESET_PATTERN;
      seg_out    <= SEG_BLANK;
      dig_sel    <= DIG_NONE;
      frame_tick <= 1'b0;
    end else begin
      // Outputs are decoded from the current state, so they trail it by one cycle.
      frame_tick <= frame_end;
      if (state == SHOW) begin
        dig_sel <= ~(4'b0001 << dig_idx);
        seg_out <= (blink_en && blink_off) ? SEG_BLANK : snap[{dig_idx, 3'b000} +: 8];
      end else begin
        dig_sel <= DIG_NONE;
        seg_out <= SEG_BLANK;
      end

      case (state)
        BLANK: begin
          if (phase_cnt == DEAD_LAST) begin
            state     <= SHOW;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (phase_cnt == DIV_LAST) begin
            state     <= BLANK;
            phase_cnt <= '0;
            dig_idx   <= dig_idx + 2'd1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: begin
          state     <= BLANK;
          phase_cnt <= '0;
        end
      endcase

      // Snapshot and blink bookkeeping advance once per frame, blink_en or not.
      if (frame_end) begin
        snap <= seg_in;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pcihellocore_hexscan.sv
// Self-checking bench: two scanner instances (DIV=4/DEAD=2 and DIV=1/DEAD=1)
// compared every cycle against a positional reference model.
module tb_pcihellocore_hexscan;
  import pcihellocore_hex_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] seg_in = 32'h11223344;
  logic        blink_en = 1'b0;

  logic [7:0]  seg_o  [2];
  logic [3:0]  dig_o  [2];
  logic        tick_o [2];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: state-cycle index since release, frame data, frame count.
  int          m_cyc   [2];
  logic [31:0] m_snap  [2];
  int          m_frame [2];

  always #5 clk = ~clk;

  pcihellocore_hexscan #(.DIV(4), .DEAD(2), .BLINK_FRAMES(2)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .seg_in     (seg_in),
    .blink_en   (blink_en),
    .seg_out    (seg_o[0]),
    .dig_sel    (dig_o[0]),
    .frame_tick (tick_o[0])
  );

  pcihellocore_hexscan #(.DIV(1), .DEAD(1), .BLINK_FRAMES(2)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .seg_in     (seg_in),
    .blink_en   (blink_en),
    .seg_out    (seg_o[1]),
    .dig_sel    (dig_o[1]),
    .frame_tick (tick_o[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict the registered outputs from the inputs sampled at this
  // edge, then compare shortly after the edge.
  task automatic step();
    logic [7:0] e_seg  [2];
    logic [3:0] e_dig  [2];
    logic       e_tick [2];
    int         cyc    [2];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int div, dead, slot, frame, pos, dig;
      div   = (k == 0) ? 4 : 1;
      dead  = (k == 0) ? 2 : 1;
      slot  = div + dead;
      frame = 4 * slot;
      cyc[k] = m_cyc[k];
      e_seg[k]  = 8'hFF;
      e_dig[k]  = 4'hF;
      e_tick[k] = 1'b0;
      if (reset) begin
        m_cyc[k]   = 0;
        m_snap[k]  = 32'h40404040;
        m_frame[k] = 0;
      end else begin
        pos = m_cyc[k] % frame;
        dig = pos / slot;
        e_tick[k] = (pos == frame - 1);
        if ((pos % slot) >= dead) begin
          e_dig[k] = ~(4'b0001 << dig);
          e_seg[k] = (blink_en && ((m_frame[k] / 2) % 2 == 1)) ? 8'hFF
                                                              : m_snap[k][8*dig +: 8];
        end
        if (e_tick[k]) begin
          m_snap[k] = seg_in;
          m_frame[k]++;
        end
        m_cyc[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("seg_out[%0d]@%0d", k, cyc[k]), {24'd0, seg_o[k]}, {24'd0, e_seg[k]});
      check($sformatf("dig_sel[%0d]@%0d", k, cyc[k]), {28'd0, dig_o[k]}, {28'd0, e_dig[k]});
      check($sformatf("frame_tick[%0d]@%0d", k, cyc[k]), {31'd0, tick_o[k]}, {31'd0, e_tick[k]});
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cyc[k]   = 0;
      m_snap[k]  = 32'h40404040;
      m_frame[k] = 0;
    end

    // Reset held with data present: data must be ignored.
    repeat (3) step();
    reset = 1'b0;

    // First SHOW output of digit 0 carries the reset pattern byte.
    repeat (3) step();
    check("first_show_seg", {24'd0, seg_o[0]}, 32'h40);
    check("first_show_dig", {28'd0, dig_o[0]}, 32'hE);

    // Five-plus frames of steady data.
    repeat (140) step();

    // New data during digit 1 SHOW must wait for the next frame.
    for (int i = 0; i < 30 && (m_cyc[0] % 24) != 8; i++) step();
    seg_in = 32'hAABBCCDD;
    repeat (50) step();

    // Random data updates at random points in the frame.
    repeat (150) begin
      if ($urandom_range(9) == 0) seg_in = $urandom;
      step();
    end

    // Blink: pairs of normal and blanked frames.
    blink_en = 1'b1;
    repeat (110) step();

    // Random blink_en toggling, including deassertion mid-SHOW.
    repeat (120) begin
      if ($urandom_range(7) == 0) blink_en = ~blink_en;
      if ($urandom_range(15) == 0) seg_in = $urandom;
      step();
    end
    blink_en = 1'b0;

    // One-cycle reset during digit 2 SHOW aborts the scan and restores the pattern.
    for (int i = 0; i < 30 && (m_cyc[0] % 24) != 14; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    check("post_reset_seg", {24'd0, seg_o[0]}, 32'h40);
    repeat (60) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pcihellocore_hexscan.md
PCIHELLOCORE_HEXSCAN -- requirements
Module: pcihellocore_hexscan

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning SHOW cycles per digit (legal range DIV >= 1).
REQ-002 SHALL have parameter DEAD, default 500, meaning blank (anti-ghost) cycles before each digit (legal range DEAD >= 1).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, meaning frames per blink half-period (legal range BLINK_FRAMES >= 1).
REQ-004 SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port seg_in, input, width 32: segment patterns from the hexdisplay PIO out_port; byte k drives digit k.
REQ-007 SHALL have port blink_en, input, width 1: 1 = blink all digits.
REQ-008 SHALL have port seg_out, output, width 8: shared active-low segment bus.
REQ-009 SHALL have port dig_sel, output, width 4: active-low digit enables, at most one low.
REQ-010 SHALL have port frame_tick, output, width 1: one-cycle pulse at frame wrap.

Function
REQ-011 SHALL scan digits in the order 0,1,2,3,0,...; each digit runs a BLANK phase of DEAD cycles, then a SHOW phase of DIV cycles; frame period = 4*(DEAD+DIV) cycles.
REQ-012 SHALL use a two-state FSM: BLANK -> SHOW when the phase counter reaches DEAD-1; SHOW -> BLANK, with digit index incremented mod 4, when the counter reaches DIV-1; the counter clears on every transition.
REQ-013 In BLANK, seg_out SHALL be 8'hFF and dig_sel SHALL be 4'hF.
REQ-014 In SHOW for digit k, dig_sel SHALL have bit k low and all other bits high, and seg_out SHALL be snap[8k+7:8k], or 8'hFF when blink_en=1 and blink phase = off.
REQ-015 All outputs SHALL be registered: a state/index change on cycle n appears on the outputs at cycle n+1.
REQ-016 snap (32 bits) SHALL load seg_in on the last SHOW cycle of digit 3 only; seg_in changes mid-frame SHALL NOT appear until the next frame (no tearing).
REQ-017 frame_tick SHALL be 1 for exactly one cycle, registered from the same event that loads snap.
REQ-018 The blink counter SHALL count frame events; at BLINK_FRAMES-1 it SHALL wrap to 0 and toggle the blink phase; the counter SHALL run regardless of blink_en.
REQ-019 Deasserting blink_en SHALL take effect on the next SHOW output cycle, with no wait for a phase boundary.
REQ-020 Counter widths SHALL be clog2 of the largest parameter value, minimum 1 bit; no wrap other than those specified.
REQ-021 When DIV=1 or DEAD=1, the corresponding phase SHALL last exactly one cycle.

Reset
REQ-022 While reset=1: FSM = BLANK, digit index = 0, phase counter = 0, blink counter = 0, blink phase = on, snap = 32'h40404040, seg_out = 8'hFF, dig_sel = 4'hF, frame_tick = 0.
REQ-023 Reset asserted mid-phase SHALL abort the scan; the first cycle after release SHALL be BLANK cycle 0 of digit 0.
REQ-024 seg_in SHALL be ignored during reset; snap keeps its reset pattern until the first frame wrap.

Structure
REQ-025 Package pcihellocore_hex_pkg SHALL hold the FSM state enum (BLANK, SHOW), HEX_RESET_PATTERN = 32'h40404040, SEG_BLANK = 8'hFF, and DIG_NONE = 4'hF.
REQ-026 SHALL be a single module with no sub-modules; the phase counter, blink counter and FSM SHALL be inline.

Verification (DIV=4, DEAD=2, BLINK_FRAMES=2; frame = 24 cycles)
REQ-027 Release reset with seg_in=32'h11223344 -> digit 0 shows 8'h40 (snap reset value); first frame_tick at cycle 24; the next frame shows 44,33,22,11 on digits 0..3.
REQ-028 Monitor over 5 frames -> each dig_sel low-window is 4 cycles, each preceded by 2 cycles of dig_sel=F and seg_out=FF; dig_sel never has two bits low.
REQ-029 Change seg_in to 32'hAABBCCDD during digit 1 SHOW -> the remainder of that frame is unchanged; the next frame shows DD,CC,BB,AA.
REQ-030 blink_en=1 -> frames alternate in pairs: 2 frames normal, 2 frames with seg_out=FF during SHOW; dig_sel timing is unchanged throughout.
REQ-031 Assert reset for 1 cycle during digit 2 SHOW -> the next cycle has outputs FF/F and frame_tick=0; the scan restarts at digit 0 and snap = 40404040.
REQ-032 DIV=1, DEAD=1 -> frame = 8 cycles; frame_tick period = 8.
